// File: rtl/instr_stream_encoder_pkg.sv
// Shared definitions for the 9-bit instruction word format.
// Holds the R/I opcode constants, the load error codes, the encoder state
// enum and the word packing helper. The legality checker and the decoder's
// verification bench both import this package, so there is one legal set.
package instr_stream_encoder_pkg;

    // R-type operation codes (4-bit field); 4'd15 is deliberately unassigned.
    localparam logic [3:0] kMV   = 4'd0;
    localparam logic [3:0] kADD  = 4'd1;
    localparam logic [3:0] kSUB  = 4'd2;
    localparam logic [3:0] kXOR  = 4'd3;
    localparam logic [3:0] kAND  = 4'd4;
    localparam logic [3:0] kXALL = 4'd5;
    localparam logic [3:0] kSLL  = 4'd6;
    localparam logic [3:0] kAS   = 4'd7;
    localparam logic [3:0] kB    = 4'd8;
    localparam logic [3:0] kBLT  = 4'd9;
    localparam logic [3:0] kBEQ  = 4'd10;
    localparam logic [3:0] kLW   = 4'd11;
    localparam logic [3:0] kSW   = 4'd12;
    localparam logic [3:0] kLUT  = 4'd13;
    localparam logic [3:0] kSTOP = 4'd14;

    // I-type operation codes (3-bit field); 3'd7 is deliberately unassigned.
    localparam logic [2:0] kLI   = 3'd0;
    localparam logic [2:0] kGBI  = 3'd1;
    localparam logic [2:0] kSB0  = 3'd2;
    localparam logic [2:0] kSB1  = 3'd3;
    localparam logic [2:0] kADDI = 3'd4;
    localparam logic [2:0] kSUBI = 3'd5;
    localparam logic [2:0] kLUTI = 3'd6;

    localparam int unsigned WordW = 9;

    typedef enum logic [1:0] {
        kErrNone     = 2'd0,
        kErrOpcode   = 2'd1,
        kErrOperand  = 2'd2,
        kErrOverflow = 2'd3
    } err_code_e;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDone,
        StErr
    } state_e;

    // R: {0, op[3:0], reg[3:0]}   I: {1, op[2:0], imm[4:0]}
    function automatic logic [WordW-1:0] encode_word(input logic       is_imm,
                                                     input logic [3:0] op,
                                                     input logic [4:0] operand);
        if (is_imm) begin
            return {1'b1, op[2:0], operand};
        end
        return {1'b0, op, operand[3:0]};
    endfunction

endpackage

// File: rtl/instr_stream_encoder_if.sv
// Field stream between an instruction producer and the encoder.
// Ports (signals): valid/ready handshake, is_imm (0 = R-type, 1 = I-type),
// op (4-bit opcode field), operand (5-bit register/immediate), last (final
// instruction of the program). master = producer, slave = encoder.
interface instr_stream_encoder_if;
    logic       valid;
    logic       ready;
    logic       is_imm;
    logic [3:0] op;
    logic [4:0] operand;
    logic       last;

    modport master (output valid, is_imm, op, operand, last, input ready);
    modport slave  (input valid, is_imm, op, operand, last, output ready);
endinterface

// File: rtl/instr_stream_encoder_legal_check.sv
// Combinational legality check for one instruction beat.
// Ports: is_imm, op, operand (beat fields) -> legal (beat may be written),
// err (kErrOpcode / kErrOperand / kErrNone). Opcode errors take priority.
module instr_legal_check
    import instr_stream_encoder_pkg::*;
(
    input  logic       is_imm,
    input  logic [3:0] op,
    input  logic [4:0] operand,
    output logic       legal,
    output err_code_e  err
);
    logic op_ok;
    logic unused_operand;

    // Only the R-type register MSB matters here; low bits are always valid.
    assign unused_operand = ^operand[3:0];

    always_comb begin
        op_ok = 1'b0;
        err   = kErrNone;
        if (is_imm) begin
            op_ok = !op[3] && (op[2:0] inside {kLI, kGBI, kSB0, kSB1, kADDI, kSUBI, kLUTI});
        end else begin
            op_ok = op inside {kMV, kADD, kSUB, kXOR, kAND, kXALL, kSLL, kAS,
                               kB, kBLT, kBEQ, kLW, kSW, kLUT, kSTOP};
        end
        if (!op_ok) begin
            err = kErrOpcode;
        end else if (!is_imm && operand[4]) begin
            err = kErrOperand;
        end
        legal = (err == kErrNone);
    end
endmodule

// File: rtl/instr_stream_encoder.sv
// Encodes a stream of instruction fields into 9-bit words and writes them
// to instruction memory starting at a base address.
// Ports: clk, rst_n (async active-low); start + base_addr begin a load;
// in_if (slave) carries the field beats; mem_wr_en/mem_addr/mem_wr_data
// drive the memory write port one cycle after a legal beat is accepted;
// busy/done/error/err_code/count report load status (done/error held).
module instr_stream_encoder
    import instr_stream_encoder_pkg::*;
#(
    parameter int unsigned AW    = 8,
    parameter int unsigned DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [AW-1:0]        base_addr,
    instr_stream_encoder_if.slave in_if,
    output logic                 mem_wr_en,
    output logic [AW-1:0]        mem_addr,
    output logic [WordW-1:0]     mem_wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           err_code,
    output logic [AW:0]          count
);
    localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);

    state_e           state_q, state_d;
    logic [AW-1:0]    base_q, base_d;
    logic [AW:0]      count_q, count_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    err_code_e        err_q, err_d;
    logic             wr_q, wr_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [WordW-1:0] data_q, data_d;

    logic      ready;
    logic      accept;
    logic      beat_legal;
    err_code_e beat_err;

    instr_legal_check u_legal (
        .is_imm  (in_if.is_imm),
        .op      (in_if.op),
        .operand (in_if.operand),
        .legal   (beat_legal),
        .err     (beat_err)
    );

    // Leaving LOAD on the accepting edge is what blocks further beats after
    // a final or failed one.
    assign ready       = (state_q == StLoad) && (count_q < DepthW);
    assign accept      = ready && in_if.valid;
    assign in_if.ready = ready;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        count_d = count_q;
        done_d  = done_q;
        error_d = error_q;
        err_d   = err_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d = StLoad;
                    base_d  = base_addr;
                    count_d = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    err_d   = kErrNone;
                end
            end
            StLoad: begin
                if (accept) begin
                    if (beat_legal) begin
                        wr_d    = 1'b1;
                        addr_d  = base_q + count_q[AW-1:0];  // wraps silently
                        data_d  = encode_word(in_if.is_imm, in_if.op, in_if.operand);
                        count_d = count_q + 1'b1;
                        if (in_if.last) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end else if (count_d == DepthW) begin
                            state_d = StErr;
                            error_d = 1'b1;
                            err_d   = kErrOverflow;
                        end
                    end else begin
                        state_d = StErr;
                        error_d = 1'b1;
                        err_d   = beat_err;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            base_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            err_q   <= kErrNone;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            done_q  <= done_d;
            error_q <= error_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign mem_wr_en   = wr_q;
    assign mem_addr    = addr_q;
    assign mem_wr_data = data_q;
    assign busy        = (state_q == StLoad);
    assign done        = done_q;
    assign error       = error_q;
    assign err_code    = err_q;
    assign count       = count_q;
endmodule
